// File: rtl/tb4004_pkg.sv
// Shared constants, state type and opcode decode for the TB4004 instruction sequencer.
package tb4004_pkg;

  localparam logic [2:0] A1 = 3'd0;
  localparam logic [2:0] A2 = 3'd1;
  localparam logic [2:0] A3 = 3'd2;
  localparam logic [2:0] M1 = 3'd3;
  localparam logic [2:0] M2 = 3'd4;
  localparam logic [2:0] X1 = 3'd5;
  localparam logic [2:0] X2 = 3'd6;
  localparam logic [2:0] X3 = 3'd7;

  localparam logic [3:0] NOP = 4'h0;
  localparam logic [3:0] JCN = 4'h1;
  localparam logic [3:0] H2  = 4'h2;
  localparam logic [3:0] H3  = 4'h3;
  localparam logic [3:0] JUN = 4'h4;
  localparam logic [3:0] JMS = 4'h5;
  localparam logic [3:0] INC = 4'h6;
  localparam logic [3:0] ISZ = 4'h7;
  localparam logic [3:0] ADD = 4'h8;
  localparam logic [3:0] SUB = 4'h9;
  localparam logic [3:0] LD  = 4'hA;
  localparam logic [3:0] XCH = 4'hB;
  localparam logic [3:0] BBL = 4'hC;
  localparam logic [3:0] LDM = 4'hD;
  localparam logic [3:0] E_  = 4'hE;
  localparam logic [3:0] F_  = 4'hF;

  typedef enum logic {
    WORD1 = 1'b0,
    WORD2 = 1'b1
  } seqState_t;

  // H2 with even OPA is FIM (two words); odd OPA is SRC (one word).
  function automatic logic isTwoByte(input logic [3:0] opr, input logic [3:0] opa);
    logic result;
    result = 1'b0;
    case (opr)
      JCN, JUN, JMS, ISZ: result = 1'b1;
      H2:                 result = ~opa[0];
      default:            result = 1'b0;
    endcase
    return result;
  endfunction

  // H3 with odd OPA is JIN, which jumps from the first word.
  function automatic logic isJin(input logic [3:0] opr, input logic [3:0] opa);
    return (opr == H3) && opa[0];
  endfunction

endpackage

// File: rtl/cycle_sequencer_phase_counter.sv
// Eight-phase wrap counter (A1..X3) with freeze input; sync is registered so it lines up with X3.
module phase_counter
  import tb4004_pkg::*;
#(
  parameter int CYCLE_W = 3
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               advance,
  output logic [CYCLE_W-1:0] cycle,
  output logic               sync,
  output logic               lastPhase
);

  logic [CYCLE_W-1:0] cycleReg;
  logic [CYCLE_W-1:0] cycleNext;
  logic               syncReg;

  assign cycleNext = cycleReg + CYCLE_W'(1);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cycleReg <= '0;
      syncReg  <= 1'b0;
    end else if (advance) begin
      cycleReg <= cycleNext;
      syncReg  <= (cycleNext == CYCLE_W'(X3));
    end
  end

  assign cycle     = cycleReg;
  assign sync      = syncReg;
  assign lastPhase = (cycleReg == CYCLE_W'(X3));

endmodule

// File: rtl/cycle_sequencer.sv
// TB4004 instruction-cycle sequencer: phase/word FSM, OPR/OPA/immediate latches and PC strobes.
// Optional build macro SEQ_SINGLE_STEP_EN adds stepReq and halts after every instruction.
module cycle_sequencer
  import tb4004_pkg::*;
#(
  parameter int CYCLE_W = 3,
  parameter int IMM_W   = 8
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               holdN,
  input  logic [3:0]         romData,
  input  logic               ccIn,
  input  logic               iszNz,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               stepReq,
`endif
  output logic [CYCLE_W-1:0] cycle,
  output logic               sync,
  output logic [3:0]         opr,
  output logic [3:0]         opa,
  output logic [IMM_W-1:0]   imm,
  output logic               word2,
  output logic               pcInc,
  output logic               pcLoad,
  output logic               instrDone
);

  seqState_t          stateReg;
  logic [3:0]         oprReg;
  logic [3:0]         opaReg;
  logic [IMM_W-1:0]   immReg;
  logic               advance;
  logic               lastPhase;
  logic               endOfWord;
  logic               twoByte;
  logic               loadCond;
  logic               doneInt;

`ifdef SEQ_SINGLE_STEP_EN
  logic haltReg;

  // Halt wins over stepReq: a completed instruction always parks, even if stepReq is still high.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      haltReg <= 1'b1;
    end else if (doneInt) begin
      haltReg <= 1'b1;
    end else if (haltReg && stepReq) begin
      haltReg <= 1'b0;
    end
  end

  assign advance = holdN && !haltReg;
`else
  assign advance = holdN;
`endif

  phase_counter #(
    .CYCLE_W (CYCLE_W)
  ) uPhase (
    .clk       (clk),
    .rstN      (rstN),
    .advance   (advance),
    .cycle     (cycle),
    .sync      (sync),
    .lastPhase (lastPhase)
  );

  // Strobes are qualified by advance, so each fires only on the clock that leaves its phase.
  assign endOfWord = advance && lastPhase;
  assign twoByte   = isTwoByte(oprReg, opaReg);

  always_comb begin
    loadCond = 1'b0;
    if (stateReg == WORD2) begin
      case (oprReg)
        JUN, JMS: loadCond = 1'b1;
        JCN:      loadCond = ccIn;
        ISZ:      loadCond = iszNz;
        default:  loadCond = 1'b0;
      endcase
    end else begin
      loadCond = isJin(oprReg, opaReg);
    end
  end

  assign doneInt = endOfWord && ((stateReg == WORD2) || !twoByte);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateReg <= WORD1;
    end else if (endOfWord) begin
      stateReg <= ((stateReg == WORD1) && twoByte) ? WORD2 : WORD1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      oprReg <= '0;
      opaReg <= '0;
      immReg <= '0;
    end else if (advance) begin
      if (cycle == CYCLE_W'(M1)) begin
        if (stateReg == WORD1) begin
          oprReg <= romData;
        end else begin
          immReg[IMM_W-1 -: 4] <= romData;
        end
      end else if (cycle == CYCLE_W'(M2)) begin
        if (stateReg == WORD1) begin
          opaReg <= romData;
        end else begin
          immReg[3:0] <= romData;
        end
      end
    end
  end

  assign opr       = oprReg;
  assign opa       = opaReg;
  assign imm       = immReg;
  assign word2     = (stateReg == WORD2);
  assign pcInc     = advance && (cycle == CYCLE_W'(A3));
  assign pcLoad    = endOfWord && loadCond;
  assign instrDone = doneInt;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: directed instruction runs plus randomized hold/reset traffic.
module tb_cycle_sequencer;

`ifdef SEQ_SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstN;
  logic       holdN;
  logic [3:0] romData;
  logic       ccIn;
  logic       iszNz;
  logic       stepReq;
  logic [2:0] cycle;
  logic       sync;
  logic [3:0] opr;
  logic [3:0] opa;
  logic [7:0] imm;
  logic       word2;
  logic       pcInc;
  logic       pcLoad;
  logic       instrDone;

  int nTests = 0;
  int nFail  = 0;
  int nInc, nLoad, nDone, nW2, nSync;

  // Reference model: phase number, which word, latched fields, halt flag.
  int         mCycle;
  bit         mWord2;
  logic [3:0] mOpr, mOpa;
  logic [7:0] mImm;
  bit         mHalt;

  always #5 clk = ~clk;

  cycle_sequencer #(.CYCLE_W(3), .IMM_W(8)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .holdN     (holdN),
    .romData   (romData),
    .ccIn      (ccIn),
    .iszNz     (iszNz),
`ifdef SEQ_SINGLE_STEP_EN
    .stepReq   (stepReq),
`endif
    .cycle     (cycle),
    .sync      (sync),
    .opr       (opr),
    .opa       (opa),
    .imm       (imm),
    .word2     (word2),
    .pcInc     (pcInc),
    .pcLoad    (pcLoad),
    .instrDone (instrDone)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mCycle = 0;
    mWord2 = 1'b0;
    mOpr   = '0;
    mOpa   = '0;
    mImm   = '0;
    mHalt  = STEP_EN;
  endtask

  task automatic clearTally();
    nInc = 0; nLoad = 0; nDone = 0; nW2 = 0; nSync = 0;
  endtask

  // Compare every output against the model, then step the model across the coming edge.
  task automatic checkOutputs();
    bit run, two, lastW, expLoad, expDone;
    run   = holdN && !(STEP_EN && mHalt);
    two   = (mOpr == 4'h1) || (mOpr == 4'h4) || (mOpr == 4'h5) || (mOpr == 4'h7) ||
            ((mOpr == 4'h2) && !mOpa[0]);
    lastW = run && (mCycle == 7);
    if (mWord2)
      expLoad = lastW && ((mOpr == 4'h4) || (mOpr == 4'h5) ||
                          ((mOpr == 4'h1) && ccIn) || ((mOpr == 4'h7) && iszNz));
    else
      expLoad = lastW && (mOpr == 4'h3) && mOpa[0];
    expDone = lastW && (mWord2 || !two);

    chk("cycle", 32'(cycle), 32'(mCycle));
    chk("sync", 32'(sync), 32'(mCycle == 7));
    chk("opr", 32'(opr), 32'(mOpr));
    chk("opa", 32'(opa), 32'(mOpa));
    chk("imm", 32'(imm), 32'(mImm));
    chk("word2", 32'(word2), 32'(mWord2));
    chk("pcInc", 32'(pcInc), 32'(run && (mCycle == 2)));
    chk("pcLoad", 32'(pcLoad), 32'(expLoad));
    chk("instrDone", 32'(instrDone), 32'(expDone));

    nInc  += int'(pcInc);
    nLoad += int'(pcLoad);
    nDone += int'(instrDone);
    nW2   += int'(word2);
    nSync += int'(sync);

    if (run) begin
      if (mCycle == 3) begin
        if (mWord2) mImm[7:4] = romData; else mOpr = romData;
      end else if (mCycle == 4) begin
        if (mWord2) mImm[3:0] = romData; else mOpa = romData;
      end
      if (mCycle == 7) mWord2 = !mWord2 && two;
      if (expDone && STEP_EN) mHalt = 1'b1;
      mCycle = (mCycle + 1) % 8;
    end else if (STEP_EN && mHalt && stepReq) begin
      mHalt = 1'b0;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic stepCycle(input logic h, input logic [3:0] rom, input logic cc,
                           input logic isz, input logic st);
    holdN   = h;
    romData = rom;
    ccIn    = cc;
    iszNz   = isz;
    stepReq = st;
    @(negedge clk);
    checkOutputs();
    @(posedge clk);
    #1;
  endtask

  task automatic runWord(input logic [3:0] hi, input logic [3:0] lo, input logic cc,
                         input logic isz, input int holdAt7, input int nCyc);
    logic [3:0] rom;
    for (int i = 0; i < nCyc; i++) begin
      rom = (i == 3) ? hi : (i == 4) ? lo : 4'($urandom);
      if (i == 7 && holdAt7 > 0) begin
        for (int h = 0; h < holdAt7; h++) stepCycle(1'b0, rom, cc, isz, 1'b0);
        chk("holdCycle", 32'(cycle), 32'd7);
        chk("holdDone", 32'(nDone), 32'd0);
      end
      stepCycle(1'b1, rom, cc, isz, 1'b0);
    end
  endtask

  task automatic doReset();
    rstN = 1'b0;
    #1;
    chk("rstCycle", 32'(cycle), 32'd0);
    chk("rstSync", 32'(sync), 32'd0);
    chk("rstOprOpa", 32'({opr, opa}), 32'd0);
    chk("rstImm", 32'(imm), 32'd0);
    chk("rstStrobes", 32'({word2, pcInc, pcLoad, instrDone}), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    rstN = 1'b0; holdN = 1'b1; romData = '0; ccIn = 1'b0; iszNz = 1'b0; stepReq = 1'b0;
    modelReset();
    clearTally();
    repeat (2) @(posedge clk);
    #1;
    doReset();

`ifndef SEQ_SINGLE_STEP_EN
    // LDM 5: one word
    clearTally();
    runWord(4'hD, 4'h5, 1'b0, 1'b0, 0, 8);
    chk("ldmInc", 32'(nInc), 32'd1);
    chk("ldmDone", 32'(nDone), 32'd1);
    chk("ldmW2", 32'(nW2), 32'd0);
    chk("ldmSync", 32'(nSync), 32'd1);
    chk("ldmOprOpa", 32'({opr, opa}), 32'hD5);

    // JUN 42 A5
    clearTally();
    runWord(4'h4, 4'h2, 1'b0, 1'b0, 0, 8);
    chk("junW1Done", 32'(nDone), 32'd0);
    runWord(4'hA, 4'h5, 1'b0, 1'b0, 0, 8);
    chk("junW2", 32'(nW2), 32'd8);
    chk("junLoad", 32'(nLoad), 32'd1);
    chk("junDone", 32'(nDone), 32'd1);
    chk("junInc", 32'(nInc), 32'd2);
    chk("junImm", 32'(imm), 32'hA5);

    // JCN with condition false then true
    for (int c = 0; c < 2; c++) begin
      clearTally();
      runWord(4'h1, 4'h4, c[0], 1'b0, 0, 8);
      runWord(4'h3, 4'h0, c[0], 1'b0, 0, 8);
      chk("jcnLoad", 32'(nLoad), 32'(c));
      chk("jcnDone", 32'(nDone), 32'd1);
    end

    // ISZ with nonzero then zero result
    for (int z = 1; z >= 0; z--) begin
      clearTally();
      runWord(4'h7, 4'h2, 1'b0, z[0], 0, 8);
      runWord(4'h5, 4'h5, 1'b0, z[0], 0, 8);
      chk("iszLoad", 32'(nLoad), 32'(z));
    end

    clearTally();
    runWord(4'h2, 4'h0, 1'b1, 1'b1, 0, 8);
    runWord(4'h1, 4'h2, 1'b1, 1'b1, 0, 8);
    chk("fimW2", 32'(nW2), 32'd8);
    chk("fimLoad", 32'(nLoad), 32'd0);
    chk("fimDone", 32'(nDone), 32'd1);

    clearTally();
    runWord(4'h2, 4'h1, 1'b1, 1'b1, 0, 8);
    chk("srcDone", 32'(nDone), 32'd1);
    chk("srcW2", 32'(nW2), 32'd0);

    clearTally();
    runWord(4'h3, 4'h1, 1'b0, 1'b0, 0, 8);
    chk("jinLoad", 32'(nLoad), 32'd1);
    chk("jinDone", 32'(nDone), 32'd1);

    // Hold for 3 clocks at X3 of JUN word 1
    clearTally();
    runWord(4'h4, 4'h2, 1'b0, 1'b0, 3, 8);
    runWord(4'hA, 4'h5, 1'b0, 1'b0, 0, 8);
    chk("holdW2", 32'(nW2), 32'd8);
    chk("holdJunDone", 32'(nDone), 32'd1);

    // Reset at cycle 5 of JUN word 2
    clearTally();
    runWord(4'h4, 4'h2, 1'b0, 1'b0, 0, 8);
    runWord(4'hA, 4'h5, 1'b0, 1'b0, 0, 5);
    doReset();
    chk("abortLoad", 32'(nLoad), 32'd0);
    chk("abortCycle", 32'(cycle), 32'd0);
    chk("abortW2", 32'(word2), 32'd0);
    clearTally();
    runWord(4'hD, 4'h5, 1'b0, 1'b0, 0, 8);
    chk("restartDone", 32'(nDone), 32'd1);
`else
    // Halted after reset until stepReq, then one LDM runs and parks.
    clearTally();
    for (int i = 0; i < 3; i++) stepCycle(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
    chk("haltCycle", 32'(cycle), 32'd0);
    chk("haltInc", 32'(nInc), 32'd0);
    stepCycle(1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    clearTally();
    runWord(4'hD, 4'h5, 1'b0, 1'b0, 0, 8);
    chk("stepDone", 32'(nDone), 32'd1);
    chk("stepOprOpa", 32'({opr, opa}), 32'hD5);
    clearTally();
    for (int i = 0; i < 3; i++) stepCycle(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
    chk("parkCycle", 32'(cycle), 32'd0);
    chk("parkInc", 32'(nInc), 32'd0);
`endif

    // Randomized traffic, including holds and occasional resets
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        doReset();
      end else begin
        stepCycle(($urandom_range(0, 4) != 0), 4'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 15) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
